coef_unload_fsm: RTL and testbench
==================================

# coef_unload_fsm

Writer-side counterpart of the coefficient loader. Snapshots a 128-entry × 16-bit coefficient register array and streams it out, two words per cycle, over a dual-port write interface (address pair + data pair). It then emits an end-of-stream marker beat with address bit 7 set, which the paired loader uses as its terminal condition. Sits between the NTT coefficient register file and the dual-port coefficient RAM or a downstream loader.

## Interface
- N, 128, number of coefficients; fixed, power of two, N ≤ 128.
- W, 16, coefficient width in bits.
- clk  in  1  clock; all logic on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  request an unload; sampled only in IDLE.
- stall  in  1  backpressure; freezes the beat counter in WRITE and MARK.
- coef_in  in  W × [N]  parallel coefficient array; sampled only in SNAP.
- busy  out  1  high in every state except IDLE.
- wr_en  out  1  write strobe for both ports; high on valid data beats only.
- addr_a  out  8  port A address; bit 7 is the end-of-stream marker.
- addr_b  out  8  port B address; bit 7 is always 0.
- data_a  out  W  port A write data.
- data_b  out  W  port B write data.
- done  out  1  one-cycle completion pulse.

## Operation
- States: IDLE → SNAP → WRITE → MARK → DONE → IDLE.
- IDLE: outputs idle. start=1 → SNAP.
- SNAP: one cycle. Copy coef_in into the internal buffer buf[0..N-1]. Clear beat counter k. Go to WRITE.
- WRITE: beat k, with k from 0 to N/2-1.
  - addr_a = {1'b0, A(2k)}, addr_b = {1'b0, A(2k+1)}.
  - data_a = buf[2k], data_b = buf[2k+1].
  - wr_en = !stall.
  - k advances only when stall=0. After beat N/2-1 is accepted → MARK.
- MARK: addr_a = 8'h80, addr_b = 8'h00, data_a = data_b = 0, wr_en = 0. Held while stall=1. Leaves to DONE on the first cycle with stall=0.
- DONE: done=1 for one cycle. Outputs otherwise idle. → IDLE.
- Address function A(i): the natural 7-bit index i. Bit-reversed when the Configuration macro is defined.
- The buffer decouples the block from the source: coef_in may change from SNAP+1 onward without affecting the output.
- start asserted outside IDLE is ignored. There is no queueing.

## Timing
- Reset values while reset_n=0, applied asynchronously:
  - state = IDLE, k = 0, buf all zero.
  - busy = 0, wr_en = 0, addr_a = addr_b = 8'h00, data_a = data_b = 0, done = 0.
- All outputs are registered. They reflect the current state and k, with no combinational path from start.
- Stall is the one exception: wr_en is deasserted in the same cycle stall is high.
- Cycle numbering: start sampled high at edge 0. Then:
  - SNAP occupies cycle 1.
  - WRITE beats occupy cycles 2..65 when no stall.
  - MARK is cycle 66; done=1 in cycle 67.
  - IDLE from cycle 68, so a new start can be sampled at edge 68.
- Each stall cycle in WRITE or MARK adds exactly one cycle to all later events.
- stall has no effect in IDLE, SNAP or DONE.
- Reset asserted mid-operation: immediate return to IDLE with reset values. done is not pulsed. The partial stream is abandoned.
- start held high continuously: a new unload begins at each IDLE visit, giving a period of 68 cycles with no stall.

## Configuration
- UNLOAD_BITREV_EN defined:
  - A(i) = bit-reverse of i over 7 bits.
  - Beat k writes buf[2k] to bitrev7(2k) and buf[2k+1] to bitrev7(2k)|7'h40.
  - This produces NTT bit-reversed storage order in the destination RAM.
- UNLOAD_BITREV_EN undefined: A(i) = i, natural order. Beat k writes addresses 2k and 2k+1.
- Timing, the MARK beat and the handshakes are identical in both builds.

## Test plan
- Reset mid-WRITE: start, then pull reset_n low at cycle 20 → all outputs 0 immediately, busy=0, no done. A new start after release is fully correct.
- Natural order, coef_in[i] = i + 16'h1000, no stall → beats on cycles 2..65.
  - Beat 0: addr_a = 0, addr_b = 1, data 16'h1000 / 16'h1001.
  - Beat 63: addr_a = 126, addr_b = 127, data 16'h107E / 16'h107F.
  - addr_a = 8'h80 with wr_en=0 on cycle 66; done on cycle 67.
- Stall: hold stall high for 3 cycles at beat 10 and 2 cycles in MARK → wr_en low during the stalls, no beat skipped or repeated, done on cycle 72.
- Snapshot isolation: change every coef_in entry to 16'hFFFF at cycle 3 → all 64 beats still carry the values sampled in SNAP.
- Ignored start: pulse start at cycle 30 → no effect; exactly 64 write beats and one done.
- UNLOAD_BITREV_EN defined:
  - Beat 0: addr_a = 0, addr_b = 64.
  - Beat 1: addr_a = 32, addr_b = 96.
  - Beat 63: addr_a = 63, addr_b = 127.
  - Data order is unchanged from the natural build.

Source files
------------

// File: rtl/coef_unload_if.sv
// Handshake and dual-port write bus between coef_unload_fsm and its RAM or loader.
interface coef_unload_if #(
  parameter int unsigned W = 16
);
  logic         start;
  logic         stall;
  logic         busy;
  logic         wr_en;
  logic [7:0]   addr_a;
  logic [7:0]   addr_b;
  logic [W-1:0] data_a;
  logic [W-1:0] data_b;
  logic         done;

  modport master (
    output start, stall,
    input  busy, wr_en, addr_a, addr_b, data_a, data_b, done
  );

  modport slave (
    input  start, stall,
    output busy, wr_en, addr_a, addr_b, data_a, data_b, done
  );
endinterface

// File: rtl/coef_unload_fsm.sv
// Snapshots N coefficients and streams them two per beat, then an end-of-stream marker.
// Define UNLOAD_BITREV_EN for bit-reversed destination addressing.
module coef_unload_fsm #(
  parameter int unsigned N = 128,
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [W-1:0] coef_in [N],
  coef_unload_if.slave bus
);
  localparam int unsigned KW = $clog2(N / 2);
  localparam int unsigned IW = $clog2(N);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SNAP  = 3'd1;
  localparam logic [2:0] S_WRITE = 3'd2;
  localparam logic [2:0] S_MARK  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]    state, state_nx;
  logic [KW-1:0] k, k_nx;
  logic [W-1:0]  coef_buf [N];
  logic          wr_q;
  logic [IW-1:0] idx_a, idx_b;
  logic [W-1:0]  src_a, src_b;

  function automatic logic [7:0] amap(input logic [IW-1:0] i);
    logic [IW-1:0] r;
`ifdef UNLOAD_BITREV_EN
    r = {<<{i}};
`else
    r = i;
`endif
    return 8'(r);
  endfunction

  always_comb begin
    state_nx = state;
    k_nx     = k;
    case (state)
      S_IDLE:  if (bus.start) state_nx = S_SNAP;
      S_SNAP:  begin
        state_nx = S_WRITE;
        k_nx     = '0;
      end
      S_WRITE: if (!bus.stall) begin
        if (k == '1) state_nx = S_MARK;
        else         k_nx     = k + 1'b1;
      end
      S_MARK:  if (!bus.stall) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state; the first beat must come
  // straight from coef_in because the buffer is loaded on that same edge.
  always_comb begin
    idx_a = {k_nx, 1'b0};
    idx_b = {k_nx, 1'b1};
    src_a = (state == S_SNAP) ? coef_in[idx_a] : coef_buf[idx_a];
    src_b = (state == S_SNAP) ? coef_in[idx_b] : coef_buf[idx_b];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      k     <= '0;
      for (int unsigned i = 0; i < N; i++) coef_buf[i] <= '0;
    end else begin
      state <= state_nx;
      k     <= k_nx;
      if (state == S_SNAP) begin
        for (int unsigned i = 0; i < N; i++) coef_buf[i] <= coef_in[i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.busy   <= 1'b0;
      wr_q       <= 1'b0;
      bus.done   <= 1'b0;
      bus.addr_a <= '0;
      bus.addr_b <= '0;
      bus.data_a <= '0;
      bus.data_b <= '0;
    end else begin
      bus.busy   <= (state_nx != S_IDLE);
      wr_q       <= (state_nx == S_WRITE);
      bus.done   <= (state_nx == S_DONE);
      bus.addr_a <= (state_nx == S_WRITE) ? amap(idx_a) :
                    (state_nx == S_MARK)  ? 8'h80 : '0;
      bus.addr_b <= (state_nx == S_WRITE) ? amap(idx_b) : '0;
      bus.data_a <= (state_nx == S_WRITE) ? src_a : '0;
      bus.data_b <= (state_nx == S_WRITE) ? src_b : '0;
    end
  end

  // Backpressure drops the strobe in the very cycle it is raised.
  assign bus.wr_en = wr_q & ~bus.stall;
endmodule

// File: tb/tb_coef_unload_fsm.sv
// Self-checking bench for coef_unload_fsm: directed table, corner sequences, random runs vs a position model.
module tb_coef_unload_fsm;
  localparam int unsigned N = 128;
  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [W-1:0] coef_in [N];

  coef_unload_if #(.W(W)) bus ();

  coef_unload_fsm #(.N(N), .W(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .coef_in (coef_in),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic        start;
    logic        busy;
    logic        wr;
    logic        done;
    logic [7:0]  aa;
    logic [7:0]  ab;
    logic [15:0] da;
    logic [15:0] db;
  } vec_t;

  vec_t         tbl [9];
  int           errors = 0;
  int           checks = 0;
  int           pos = 0;      // 0 idle, 1 snap, 2..65 beat pos-2, 66 marker, 67 done
  logic [W-1:0] snap [N];
  logic [50:0]  last_obs;
  int           done_cnt, beat_cnt, ff_cnt;

  function automatic logic [7:0] amap(input int i);
    int r = 0;
`ifdef UNLOAD_BITREV_EN
    for (int j = 0; j < 7; j++) r = r * 2 + ((i >> j) & 1);
`else
    r = i;
`endif
    return 8'(r);
  endfunction

  function automatic logic [50:0] pack(input logic b, input logic w, input logic d,
                                       input logic [7:0] aa, input logic [7:0] ab,
                                       input logic [15:0] da, input logic [15:0] db);
    return {b, w, d, aa, ab, da, db};
  endfunction

  function automatic vec_t mkvec(input int c, input logic st, input logic b, input logic w,
                                 input logic d, input logic [7:0] aa, input logic [7:0] ab,
                                 input logic [15:0] da, input logic [15:0] db);
    vec_t v;
    v.cyc = c; v.start = st; v.busy = b; v.wr = w; v.done = d;
    v.aa = aa; v.ab = ab; v.da = da; v.db = db;
    return v;
  endfunction

  function automatic logic [50:0] actual();
    return pack(bus.busy, bus.wr_en, bus.done, bus.addr_a, bus.addr_b, bus.data_a, bus.data_b);
  endfunction

  function automatic logic [50:0] expect_out(input logic sl);
    int b;
    if (pos == 0) return '0;
    if (pos == 1) return pack(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 16'h0, 16'h0);
    if (pos <= 65) begin
      b = pos - 2;
      return pack(1'b1, !sl, 1'b0, amap(2 * b), amap(2 * b + 1), snap[2 * b], snap[2 * b + 1]);
    end
    if (pos == 66) return pack(1'b1, 1'b0, 1'b0, 8'h80, 8'h00, 16'h0, 16'h0);
    return pack(1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 16'h0, 16'h0);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (pos=%0d)", name, act, exp, pos);
    end
  endtask

  task automatic clr_counts();
    done_cnt = 0; beat_cnt = 0; ff_cnt = 0;
  endtask

  // One clock cycle: drive, sample mid-cycle against the model, then advance the model.
  task automatic cyc(input logic st, input logic sl);
    logic [50:0] e;
    bus.start = st;
    bus.stall = sl;
    #4;
    last_obs = actual();
    e = expect_out(sl);
    check("cycle", 64'(last_obs), 64'(e));
    if (bus.done) done_cnt++;
    if (bus.wr_en) beat_cnt++;
    if (bus.wr_en && bus.data_a == 16'hFFFF) ff_cnt++;
    @(posedge clk);
    if (!reset_n) pos = 0;
    else begin
      if (pos == 1) for (int i = 0; i < N; i++) snap[i] = coef_in[i];
      if (pos == 0)                           pos = st ? 1 : 0;
      else if (pos >= 2 && pos <= 66 && sl)   pos = pos;
      else if (pos == 67)                     pos = 0;
      else                                    pos = pos + 1;
    end
    #1;
  endtask

  task automatic fill_ramp();
    for (int i = 0; i < N; i++) coef_in[i] = 16'h1000 + 16'(i);
  endtask

  task automatic fill_rand();
    for (int i = 0; i < N; i++) coef_in[i] = 16'($urandom);
  endtask

  initial begin
    int done_at;
    int dq [$];
    logic st, sl;

    tbl[0] = mkvec(0,  1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 16'h0, 16'h0);
    tbl[1] = mkvec(1,  1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 16'h0, 16'h0);
    tbl[2] = mkvec(2,  1'b0, 1'b1, 1'b1, 1'b0, amap(0), amap(1), 16'h1000, 16'h1001);
    tbl[3] = mkvec(3,  1'b0, 1'b1, 1'b1, 1'b0, amap(2), amap(3), 16'h1002, 16'h1003);
    tbl[4] = mkvec(65, 1'b0, 1'b1, 1'b1, 1'b0, amap(126), amap(127), 16'h107E, 16'h107F);
    tbl[5] = mkvec(66, 1'b0, 1'b1, 1'b0, 1'b0, 8'h80, 8'h00, 16'h0, 16'h0);
    tbl[6] = mkvec(67, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 16'h0, 16'h0);
    tbl[7] = mkvec(68, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 16'h0, 16'h0);
    tbl[8] = mkvec(69, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 16'h0, 16'h0);

    reset_n = 1'b0;
    bus.start = 1'b0;
    bus.stall = 1'b1;
    fill_ramp();
    #2;
    check("reset_outputs", 64'(actual()), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    cyc(1'b0, 1'b0);

    // Directed natural/bitrev table, no stall
    clr_counts();
    for (int c = 0; c < 70; c++) begin
      st = 1'b0;
      foreach (tbl[v]) if (tbl[v].cyc == c) st = tbl[v].start;
      cyc(st, 1'b0);
      foreach (tbl[v]) if (tbl[v].cyc == c)
        check($sformatf("table_c%0d", c), 64'(last_obs),
              64'(pack(tbl[v].busy, tbl[v].wr, tbl[v].done, tbl[v].aa, tbl[v].ab, tbl[v].da, tbl[v].db)));
    end
    check("table_beats", 64'(beat_cnt), 64'd64);

    // Stall 3 cycles at beat 10 and 2 cycles in the marker
    fill_rand();
    clr_counts();
    done_at = -1;
    for (int c = 0; c < 80; c++) begin
      sl = ((c >= 12 && c <= 14) || c == 69 || c == 70);
      cyc(c == 0, sl);
      if (last_obs[48]) done_at = c;
    end
    check("stall_done_cycle", 64'(done_at), 64'd72);
    check("stall_beats", 64'(beat_cnt), 64'd64);

    // Snapshot isolation: source overwritten from cycle 3
    fill_ramp();
    clr_counts();
    for (int c = 0; c < 70; c++) begin
      if (c == 3) for (int i = 0; i < N; i++) coef_in[i] = 16'hFFFF;
      cyc(c == 0, 1'b0);
    end
    check("snap_no_ffff", 64'(ff_cnt), 64'd0);
    check("snap_beats", 64'(beat_cnt), 64'd64);

    // Start pulsed mid-stream is ignored
    fill_rand();
    clr_counts();
    for (int c = 0; c < 76; c++) cyc(c == 0 || c == 30, 1'b0);
    check("ignored_start_beats", 64'(beat_cnt), 64'd64);
    check("ignored_start_done", 64'(done_cnt), 64'd1);

    // Reset in the middle of WRITE
    fill_rand();
    clr_counts();
    for (int c = 0; c < 20; c++) cyc(c == 0, 1'b0);
    reset_n = 1'b0;
    pos = 0;
    #1;
    check("reset_mid_outputs", 64'(actual()), 64'd0);
    for (int c = 0; c < 3; c++) cyc(1'b0, 1'b0);
    reset_n = 1'b1;
    check("reset_mid_no_done", 64'(done_cnt), 64'd0);
    clr_counts();
    fill_ramp();
    for (int c = 0; c < 70; c++) cyc(c == 0, 1'b0);
    check("after_reset_beats", 64'(beat_cnt), 64'd64);
    check("after_reset_done", 64'(done_cnt), 64'd1);

    // Start held high: back-to-back unloads every 68 cycles
    fill_rand();
    clr_counts();
    for (int c = 0; c < 140; c++) begin
      cyc(1'b1, 1'b0);
      if (last_obs[48]) dq.push_back(c);
    end
    for (int c = 0; c < 75; c++) cyc(1'b0, 1'b0);
    check("cont_done_count", 64'(dq.size()), 64'd2);
    if (dq.size() == 2) begin
      check("cont_done0", 64'(dq[0]), 64'd67);
      check("cont_done1", 64'(dq[1]), 64'd135);
    end

    // Random data, stall and spurious start
    for (int r = 0; r < 6; r++) begin
      fill_rand();
      clr_counts();
      for (int c = 0; c < 400 && done_cnt == 0; c++) begin
        st = (c == 0) || ($urandom_range(0, 15) == 0);
        sl = ($urandom_range(0, 3) == 0);
        cyc(st, sl);
        if (c > 2 && c < 40 && $urandom_range(0, 7) == 0)
          for (int i = 0; i < N; i++) coef_in[i] = 16'($urandom);
      end
      check("rand_done", 64'(done_cnt), 64'd1);
      check("rand_beats", 64'(beat_cnt), 64'd64);
      cyc(1'b0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
